// File: rtl/decode_stage_if.sv
// Bundle of the fetch-side, write-back and decode-output signals of the decode stage.
// master drives the fetch/write-back inputs; slave is the decode stage itself.
interface decode_stage_if #(
  parameter int WIDTH = 32
);
  logic [31:0]      ins_in;
  logic [31:0]      pcp4_in;
  logic             in_valid;
  logic             stall;
  logic             flush;
  logic             wb_en;
  logic [4:0]       wb_addr;
  logic [WIDTH-1:0] wb_data;

  logic             out_valid;
  logic [31:0]      ins;
  logic [31:0]      pcp4;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic [WIDTH-1:0] imm;
  logic [31:0]      jtarget;

  modport master (
    output ins_in, pcp4_in, in_valid, stall, flush, wb_en, wb_addr, wb_data,
    input  out_valid, ins, pcp4, rs, rt, rd, rd1, rd2, imm, jtarget
  );

  modport slave (
    input  ins_in, pcp4_in, in_valid, stall, flush, wb_en, wb_addr, wb_data,
    output out_valid, ins, pcp4, rs, rt, rd, rd1, rd2, imm, jtarget
  );
endinterface

// File: rtl/decode_stage.sv
// MIPS-style instruction decode: IF/ID pipeline register with stall/flush, register file
// with write-through bypass from write-back, and immediate / jump-target extraction.
module decode_stage #(
  parameter int WIDTH = 32,
  parameter int NREG  = 32
) (
  input  logic           clk,
  input  logic           rst,
  decode_stage_if.slave  bus
);

  logic             valid_q, valid_d;
  logic [31:0]      ins_q, ins_d;
  logic [31:0]      pcp4_q, pcp4_d;
  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];

  logic [4:0]       rs, rt, rd;
  logic             wb_write;
  logic             byp_rs, byp_rt;
  logic [WIDTH-1:0] rf_rs, rf_rt;

  // Flush beats stall; a bubble still captures ins_in verbatim when in_valid is low.
  always_comb begin
    valid_d = valid_q;
    ins_d   = ins_q;
    pcp4_d  = pcp4_q;
    if (bus.flush) begin
      valid_d = 1'b0;
      ins_d   = '0;
      pcp4_d  = '0;
    end else if (!bus.stall) begin
      valid_d = bus.in_valid;
      ins_d   = bus.ins_in;
      pcp4_d  = bus.pcp4_in;
    end
  end

  assign wb_write = bus.wb_en && (bus.wb_addr != 5'd0) && !rst;

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    for (int i = 1; i < NREG; i++) begin
      if (wb_write && (bus.wb_addr == 5'(i))) begin
        regs_d[i] = bus.wb_data;
      end
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ins_q   <= '0;
      pcp4_q  <= '0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      ins_q   <= ins_d;
      pcp4_q  <= pcp4_d;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign rs = ins_q[25:21];
  assign rt = ins_q[20:16];
  assign rd = ins_q[15:11];

  // Register 0 is never selected, so it reads as zero regardless of its flop contents.
  always_comb begin
    rf_rs = '0;
    rf_rt = '0;
    for (int i = 1; i < NREG; i++) begin
      if (rs == 5'(i)) rf_rs = regs_q[i];
      if (rt == 5'(i)) rf_rt = regs_q[i];
    end
  end

  assign byp_rs = bus.wb_en && (bus.wb_addr != 5'd0) && (bus.wb_addr == rs);
  assign byp_rt = bus.wb_en && (bus.wb_addr != 5'd0) && (bus.wb_addr == rt);

  assign bus.out_valid = valid_q;
  assign bus.ins       = ins_q;
  assign bus.pcp4      = pcp4_q;
  assign bus.rs        = rs;
  assign bus.rt        = rt;
  assign bus.rd        = rd;
  assign bus.rd1       = byp_rs ? bus.wb_data : rf_rs;
  assign bus.rd2       = byp_rt ? bus.wb_data : rf_rt;
  assign bus.imm       = {{(WIDTH-16){ins_q[15]}}, ins_q[15:0]};
  assign bus.jtarget   = {pcp4_q[31:28], ins_q[25:0], 2'b00};

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized run
// compared against a simple behavioural model of the pipeline register and register file.
module tb_decode_stage;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_stage_if #(.WIDTH(WIDTH)) bus ();
  decode_stage #(.WIDTH(WIDTH), .NREG(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int passed = 0;

  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [31:0] m_ins;
  logic [31:0] m_pcp4;

  // Advance the model by one edge using the inputs currently applied, then clock the DUT.
  task automatic tick();
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_valid = 1'b0;
      m_ins   = 32'd0;
      m_pcp4  = 32'd0;
    end else begin
      if (bus.wb_en && bus.wb_addr != 5'd0) m_regs[bus.wb_addr] = bus.wb_data;
      if (bus.flush) begin
        m_valid = 1'b0;
        m_ins   = 32'd0;
        m_pcp4  = 32'd0;
      end else if (!bus.stall) begin
        m_valid = bus.in_valid;
        m_ins   = bus.ins_in;
        m_pcp4  = bus.pcp4_in;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (bus.wb_en && a != 5'd0 && bus.wb_addr == a) return bus.wb_data;
    if (a == 5'd0) return 32'd0;
    return m_regs[a];
  endfunction

  task automatic idle_inputs();
    bus.ins_in = 32'd0; bus.pcp4_in = 32'd0; bus.in_valid = 1'b0;
    bus.stall = 1'b0; bus.flush = 1'b0;
    bus.wb_en = 1'b0; bus.wb_addr = 5'd0; bus.wb_data = 32'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.ins_in = 32'hCAFE_1234; bus.pcp4_in = 32'h0000_0104; bus.in_valid = 1'b1;
    bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'hA5A5_A5A5;
    tick();
    rst = 1'b0;
    idle_inputs();
    #1;
    checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %0b want 0", bus.out_valid); else passed++;
    checks++; if (bus.ins !== 32'd0) $display("[TB] FAIL reset_ins: got %h want 0", bus.ins); else passed++;
    checks++; if (bus.pcp4 !== 32'd0) $display("[TB] FAIL reset_pcp4: got %h want 0", bus.pcp4); else passed++;
    for (int i = 0; i < 32; i++) begin
      bus.ins_in = {6'd0, 5'(i), 5'((i + 1) % 32), 16'd0};
      bus.in_valid = 1'b1;
      tick();
      checks++; if (bus.rd1 !== 32'd0) $display("[TB] FAIL reset_reg_rd1[%0d]: got %h want 0", i, bus.rd1); else passed++;
      checks++; if (bus.rd2 !== 32'd0) $display("[TB] FAIL reset_reg_rd2[%0d]: got %h want 0", (i + 1) % 32, bus.rd2); else passed++;
    end
    idle_inputs();
  endtask

  task automatic test_decode_fields();
    bus.wb_en = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEAD_BEEF;
    tick();
    bus.wb_en = 1'b0;
    bus.ins_in = 32'h00A6_2020; bus.pcp4_in = 32'h0040_0008; bus.in_valid = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL fields_valid: got %0b want 1", bus.out_valid); else passed++;
    checks++; if (bus.rs !== 5'd5) $display("[TB] FAIL fields_rs: got %0d want 5", bus.rs); else passed++;
    checks++; if (bus.rt !== 5'd6) $display("[TB] FAIL fields_rt: got %0d want 6", bus.rt); else passed++;
    checks++; if (bus.rd !== 5'd4) $display("[TB] FAIL fields_rd: got %0d want 4", bus.rd); else passed++;
    checks++; if (bus.rd1 !== 32'hDEAD_BEEF) $display("[TB] FAIL fields_rd1: got %h want deadbeef", bus.rd1); else passed++;
    checks++; if (bus.rd2 !== 32'd0) $display("[TB] FAIL fields_rd2: got %h want 0", bus.rd2); else passed++;
    checks++; if (bus.pcp4 !== 32'h0040_0008) $display("[TB] FAIL fields_pcp4: got %h want 00400008", bus.pcp4); else passed++;
  endtask

  task automatic test_reg_zero();
    bus.wb_en = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'h0000_1234;
    tick();
    bus.wb_en = 1'b0;
    bus.ins_in = 32'h0000_2020; bus.in_valid = 1'b1;
    tick();
    checks++; if (bus.rd1 !== 32'd0) $display("[TB] FAIL r0_read: got %h want 0", bus.rd1); else passed++;
    bus.wb_en = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'h0000_1234;
    #1;
    checks++; if (bus.rd1 !== 32'd0) $display("[TB] FAIL r0_bypass: got %h want 0", bus.rd1); else passed++;
    bus.wb_en = 1'b0;
  endtask

  task automatic test_bypass();
    bus.ins_in = 32'h00A6_2020; bus.in_valid = 1'b1;
    tick();
    bus.wb_en = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h1111_1111;
    #1;
    checks++; if (bus.rd1 !== 32'h1111_1111) $display("[TB] FAIL bypass_pre_edge: got %h want 11111111", bus.rd1); else passed++;
    checks++; if (bus.rd2 !== 32'd0) $display("[TB] FAIL bypass_rt_untouched: got %h want 0", bus.rd2); else passed++;
    tick();
    bus.wb_en = 1'b0;
    #1;
    checks++; if (bus.rd1 !== 32'h1111_1111) $display("[TB] FAIL bypass_post_edge: got %h want 11111111", bus.rd1); else passed++;
  endtask

  task automatic test_stall_flush();
    bus.ins_in = 32'h00A6_2020; bus.pcp4_in = 32'h0000_0010; bus.in_valid = 1'b1;
    tick();
    bus.stall = 1'b1; bus.ins_in = 32'h2008_FFFC; bus.pcp4_in = 32'h0000_0014;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.ins !== 32'h00A6_2020) $display("[TB] FAIL stall_ins[%0d]: got %h want 00a62020", i, bus.ins); else passed++;
      checks++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL stall_valid[%0d]: got %0b want 1", i, bus.out_valid); else passed++;
    end
    bus.flush = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL flush_valid: got %0b want 0", bus.out_valid); else passed++;
    checks++; if (bus.ins !== 32'd0) $display("[TB] FAIL flush_ins: got %h want 0", bus.ins); else passed++;
    checks++; if (bus.pcp4 !== 32'd0) $display("[TB] FAIL flush_pcp4: got %h want 0", bus.pcp4); else passed++;
    bus.stall = 1'b0; bus.flush = 1'b0;
    bus.ins_in = 32'h1234_5678; bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL bubble_valid: got %0b want 0", bus.out_valid); else passed++;
    checks++; if (bus.ins !== 32'h1234_5678) $display("[TB] FAIL bubble_ins: got %h want 12345678", bus.ins); else passed++;
  endtask

  task automatic test_imm_jtarget();
    bus.ins_in = 32'h2008_FFFC; bus.in_valid = 1'b1;
    tick();
    checks++; if (bus.imm !== 32'hFFFF_FFFC) $display("[TB] FAIL imm_neg: got %h want fffffffc", bus.imm); else passed++;
    bus.ins_in = 32'h0810_0003; bus.pcp4_in = 32'h0040_0004;
    tick();
    checks++; if (bus.jtarget !== 32'h0040_000C) $display("[TB] FAIL jtarget: got %h want 0040000c", bus.jtarget); else passed++;
    checks++; if (bus.imm !== 32'h0000_0003) $display("[TB] FAIL imm_pos: got %h want 00000003", bus.imm); else passed++;
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [31:0] e_imm, e_jt;
    for (int n = 0; n < 400; n++) begin
      r = $urandom;
      r[25:21] = 5'($urandom_range(0, 7));
      r[20:16] = 5'($urandom_range(0, 7));
      bus.ins_in   = r;
      bus.pcp4_in  = $urandom;
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.stall    = ($urandom_range(0, 3) == 0);
      bus.flush    = ($urandom_range(0, 9) == 0);
      bus.wb_en    = 1'($urandom_range(0, 1));
      bus.wb_addr  = 5'($urandom_range(0, 7));
      bus.wb_data  = $urandom;
      rst          = ($urandom_range(0, 39) == 0);
      #1;
      e_imm = 32'($signed(m_ins[15:0]));
      e_jt  = (m_pcp4 & 32'hF000_0000) | ((m_ins & 32'h03FF_FFFF) << 2);
      checks++; if (bus.out_valid !== m_valid) $display("[TB] FAIL rnd_valid@%0d: got %0b want %0b", n, bus.out_valid, m_valid); else passed++;
      checks++; if (bus.ins !== m_ins) $display("[TB] FAIL rnd_ins@%0d: got %h want %h", n, bus.ins, m_ins); else passed++;
      checks++; if (bus.pcp4 !== m_pcp4) $display("[TB] FAIL rnd_pcp4@%0d: got %h want %h", n, bus.pcp4, m_pcp4); else passed++;
      checks++; if (bus.rs !== 5'((m_ins >> 21) & 31)) $display("[TB] FAIL rnd_rs@%0d: got %0d want %0d", n, bus.rs, (m_ins >> 21) & 31); else passed++;
      checks++; if (bus.rt !== 5'((m_ins >> 16) & 31)) $display("[TB] FAIL rnd_rt@%0d: got %0d want %0d", n, bus.rt, (m_ins >> 16) & 31); else passed++;
      checks++; if (bus.rd !== 5'((m_ins >> 11) & 31)) $display("[TB] FAIL rnd_rd@%0d: got %0d want %0d", n, bus.rd, (m_ins >> 11) & 31); else passed++;
      checks++; if (bus.rd1 !== exp_read(5'((m_ins >> 21) & 31))) $display("[TB] FAIL rnd_rd1@%0d: got %h want %h", n, bus.rd1, exp_read(5'((m_ins >> 21) & 31))); else passed++;
      checks++; if (bus.rd2 !== exp_read(5'((m_ins >> 16) & 31))) $display("[TB] FAIL rnd_rd2@%0d: got %h want %h", n, bus.rd2, exp_read(5'((m_ins >> 16) & 31))); else passed++;
      checks++; if (bus.imm !== e_imm) $display("[TB] FAIL rnd_imm@%0d: got %h want %h", n, bus.imm, e_imm); else passed++;
      checks++; if (bus.jtarget !== e_jt) $display("[TB] FAIL rnd_jtarget@%0d: got %h want %h", n, bus.jtarget, e_jt); else passed++;
      tick();
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_decode_fields();
    test_reg_zero();
    test_bypass();
    test_stall_flush();
    test_imm_jtarget();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
